// File: rtl/dpi_mem_pkg.sv
// Shared types and memory-access hooks for dpi_mem_port and the random-stall models built on it.
package dpi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Galois feedback for x^16 + x^14 + x^13 + x^11 + 1 in right-shifting form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Memory model with the pmem_read/pmem_write signatures; call counters aid debug.
  int unsigned pmem_rd_calls = 0;
  int unsigned pmem_wr_calls = 0;
  int          pmem_store [int];

  function automatic int pmem_read(input int raddr);
    int key;
    key = {raddr[31:2], 2'b00};
    pmem_rd_calls = pmem_rd_calls + 1;
    if (pmem_store.exists(key)) return pmem_store[key];
    return 0;
  endfunction

  function automatic void pmem_write(input int waddr, input int wdata, input byte wmask);
    int          key;
    logic [31:0] word;
    key  = {waddr[31:2], 2'b00};
    word = pmem_store.exists(key) ? pmem_store[key] : 32'd0;
    for (int i = 0; i < 4; i++)
      if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
    pmem_store[key] = word;
    pmem_wr_calls = pmem_wr_calls + 1;
  endfunction

endpackage

// File: rtl/dpi_mem_port_lfsr.sv
// 16-bit Galois LFSR that free-runs while out of reset; reset reloads the seed for reproducible runs.
module dpi_lfsr16
  import dpi_mem_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  always_ff @(posedge clock) begin
    if (!resetn) out <= seed;
    else         out <= {1'b0, out[15:1]} ^ (out[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/dpi_mem_port.sv
// Simulation memory slave: valid/ready request and response channels around pmem_read/pmem_write.
// One outstanding request; fixed latency plus optional LFSR-driven extra delay; window check.
module dpi_mem_port
  import dpi_mem_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          LATENCY   = 1,
  parameter int          RAND_W    = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter logic [31:0] SIZE      = 32'h0800_0000
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(LATENCY + 256);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $fatal(1, "dpi_mem_port: DATA_W must be 32 or 64");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $fatal(1, "dpi_mem_port: LATENCY must be at least 1");
  end
  if (RAND_W < 0 || RAND_W > 8) begin : g_bad_rand_w
    $fatal(1, "dpi_mem_port: RAND_W must be in 0..8");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $fatal(1, "dpi_mem_port: LFSR_SEED must be non-zero");
  end

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    extra;
  logic [15:0]         lfsr;
  logic                wr_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [31:0]         wdata_lo, wdata_hi;
  logic [3:0]          wmask_lo, wmask_hi;
  logic                in_range;

  dpi_lfsr16 u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .seed   (LFSR_SEED),
    .out    (lfsr)
  );

  // A zero-width random field masks to zero, which leaves the fixed latency alone.
  assign extra = CNT_W'(lfsr & 16'((1 << RAND_W) - 1));

  assign wdata_lo = wdata_q[31:0];
  assign wmask_lo = wmask_q[3:0];
  if (DATA_W == 64) begin : g_wide
    assign wdata_hi = wdata_q[DATA_W-1:32];
    assign wmask_hi = wmask_q[MASK_W-1:4];
  end else begin : g_narrow
    assign wdata_hi = '0;
    assign wmask_hi = '0;
  end

  // 33-bit compare so a window ending at 2^32 cannot wrap into a false hit.
  assign in_range = ({1'b0, addr_q} >= {1'b0, BASE}) &&
                    (({1'b0, addr_q} - {1'b0, BASE}) < {1'b0, SIZE});

  assign req_ready = resetn && (state == IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req_valid) next_state = WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr & ~32'(MASK_W - 1);
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            cnt     <= CNT_W'(LATENCY - 1) + extra;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= !in_range;
            rsp_rdata <= '0;
            if (in_range && !wr_q)
              rsp_rdata <= DATA_W'({(DATA_W == 64) ? pmem_read(addr_q + 32'd4) : 32'd0,
                                    pmem_read(addr_q)});
            if (in_range && wr_q) begin
              if (wmask_lo != 4'h0) pmem_write(addr_q, wdata_lo, {4'b0000, wmask_lo});
              if (wmask_hi != 4'h0) pmem_write(addr_q + 32'd4, wdata_hi, {4'b0000, wmask_hi});
            end
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dpi_mem_port.sv
// Directed bench for dpi_mem_port: four configurations sharing one backing memory, scoreboard of responses.
module tb_dpi_mem_port;

  localparam int N = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0] resetn, req_valid, req_wr, rsp_ready;
  logic [N-1:0] req_ready, rsp_valid, rsp_err;
  logic [31:0]  req_addr  [N];
  logic [63:0]  req_wdata [N];
  logic [7:0]   req_wmask [N];
  logic [31:0]  rdata0, rdata1, rdata3;
  logic [63:0]  rdata2;

  dpi_mem_port #(.DATA_W(32), .LATENCY(1), .RAND_W(0)) u_lat1 (
    .clock(clock), .resetn(resetn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0][31:0]),
    .req_wmask(req_wmask[0][3:0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rdata0), .rsp_err(rsp_err[0]));

  dpi_mem_port #(.DATA_W(32), .LATENCY(4), .RAND_W(0)) u_lat4 (
    .clock(clock), .resetn(resetn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wr(req_wr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1][31:0]),
    .req_wmask(req_wmask[1][3:0]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rdata1), .rsp_err(rsp_err[1]));

  dpi_mem_port #(.DATA_W(64), .LATENCY(2), .RAND_W(0)) u_wide (
    .clock(clock), .resetn(resetn[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wr(req_wr[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wmask(req_wmask[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rdata2), .rsp_err(rsp_err[2]));

  dpi_mem_port #(.DATA_W(32), .LATENCY(2), .RAND_W(3)) u_rand (
    .clock(clock), .resetn(resetn[3]), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
    .req_wr(req_wr[3]), .req_addr(req_addr[3]), .req_wdata(req_wdata[3][31:0]),
    .req_wmask(req_wmask[3][3:0]), .rsp_valid(rsp_valid[3]), .rsp_ready(rsp_ready[3]),
    .rsp_rdata(rdata3), .rsp_err(rsp_err[3]));

  // Reference LFSR for u_rand: x^16+x^14+x^13+x^11+1, seed 0xACE1.
  logic [15:0] m_lfsr;
  always @(posedge clock) begin
    if (!resetn[3]) m_lfsr <= 16'hACE1;
    else            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct {
    int          id;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd(input int id);
    case (id)
      0:       return {32'b0, rdata0};
      1:       return {32'b0, rdata1};
      2:       return rdata2;
      default: return {32'b0, rdata3};
    endcase
  endfunction

  // exp_lat < 0 derives the latency from the reference LFSR (u_rand: LATENCY 2 + 3 random bits).
  task automatic xfer(input string tag, input int id, input logic wr, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [7:0] wm, input logic [63:0] exp_d,
                      input logic exp_e, input int exp_lat, input int hold, output int lat);
    int   cyc;
    int   e_lat;
    exp_t it;
    @(negedge clock);
    req_valid[id] = 1'b1;
    req_wr[id]    = wr;
    req_addr[id]  = addr;
    req_wdata[id] = wd;
    req_wmask[id] = wm;
    cyc = 0;
    while (!req_ready[id] && cyc < 64) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "/req_ready"}, 64'(req_ready[id]), 64'd1);
    e_lat = (exp_lat < 0) ? 2 + int'(m_lfsr[2:0]) : exp_lat;
    sb.push_back('{id: id, rdata: exp_d, err: exp_e});
    @(posedge clock);
    #1 req_valid[id] = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(negedge clock);
      if (rsp_valid[id]) break;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(e_lat));
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check({tag, "/held_valid"}, 64'(rsp_valid[id]), 64'd1);
      check({tag, "/held_rdata"}, rd(id), sb[0].rdata);
      check({tag, "/held_err"}, 64'(rsp_err[id]), 64'(sb[0].err));
      check({tag, "/held_req_ready"}, 64'(req_ready[id]), 64'd0);
    end
    it = sb.pop_front();
    check({tag, "/rdata"}, rd(id), it.rdata);
    check({tag, "/err"}, 64'(rsp_err[id]), 64'(it.err));
    rsp_ready[id] = 1'b1;
    @(posedge clock);
    #1 rsp_ready[id] = 1'b0;
    @(negedge clock);
    check({tag, "/valid_drop"}, 64'(rsp_valid[id]), 64'd0);
    check({tag, "/ready_back"}, 64'(req_ready[id]), 64'd1);
  endtask

  initial begin
    int          lat;
    int          lats1 [100];
    int unsigned wr0, rd0;

    resetn    = '0;
    req_valid = '0;
    req_wr    = '0;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_wmask[i] = '0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset/req_ready", 64'(req_ready), 64'd0);
    check("reset/rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset/rsp_err", 64'(rsp_err), 64'd0);
    for (int i = 0; i < N; i++) check("reset/rsp_rdata", rd(i), 64'd0);
    resetn = '1;
    @(negedge clock);
    check("post_reset/req_ready", 64'(req_ready), 64'hF);

    // LATENCY=1 write then read, sub-word mask, ignored low address bits
    xfer("l1_wr", 0, 1'b1, 32'h8000_0000, 64'hDEAD_BEEF, 8'h0F, 64'h0, 1'b0, 1, 0, lat);
    xfer("l1_rd", 0, 1'b0, 32'h8000_0000, 64'h0, 8'h0, 64'hDEAD_BEEF, 1'b0, 1, 0, lat);
    xfer("l1_wr_byte1", 0, 1'b1, 32'h8000_0000, 64'h0000_7700, 8'h02, 64'h0, 1'b0, 1, 0, lat);
    xfer("l1_rd_unaligned", 0, 1'b0, 32'h8000_0003, 64'h0, 8'h0, 64'hDEAD_77EF, 1'b0, 1, 0, lat);

    wr0 = dpi_mem_pkg::pmem_wr_calls;
    xfer("l1_wr_mask0", 0, 1'b1, 32'h8000_0000, 64'hFFFF_FFFF, 8'h00, 64'h0, 1'b0, 1, 0, lat);
    check("l1_wr_mask0/no_dpi", 64'(dpi_mem_pkg::pmem_wr_calls), 64'(wr0));
    xfer("l1_rd_after_mask0", 0, 1'b0, 32'h8000_0000, 64'h0, 8'h0, 64'hDEAD_77EF, 1'b0, 1, 0, lat);

    // window boundaries
    rd0 = dpi_mem_pkg::pmem_rd_calls;
    xfer("oob_below", 0, 1'b0, 32'h7FFF_FFFC, 64'h0, 8'h0, 64'h0, 1'b1, 1, 0, lat);
    xfer("oob_wrap", 0, 1'b0, 32'hFFFF_FFFC, 64'h0, 8'h0, 64'h0, 1'b1, 1, 0, lat);
    check("oob_rd/no_dpi", 64'(dpi_mem_pkg::pmem_rd_calls), 64'(rd0));
    wr0 = dpi_mem_pkg::pmem_wr_calls;
    xfer("oob_above_wr", 0, 1'b1, 32'h8800_0000, 64'h1234_5678, 8'h0F, 64'h0, 1'b1, 1, 0, lat);
    check("oob_wr/no_dpi", 64'(dpi_mem_pkg::pmem_wr_calls), 64'(wr0));
    xfer("top_word_wr", 0, 1'b1, 32'h87FF_FFFC, 64'hCAFE_F00D, 8'h0F, 64'h0, 1'b0, 1, 0, lat);
    xfer("top_word_rd", 0, 1'b0, 32'h87FF_FFFC, 64'h0, 8'h0, 64'hCAFE_F00D, 1'b0, 1, 0, lat);

    // LATENCY=4 with a stalled response
    xfer("l4_wr", 1, 1'b1, 32'h8000_0010, 64'h600D_F00D, 8'h0F, 64'h0, 1'b0, 4, 0, lat);
    xfer("l4_rd_held", 1, 1'b0, 32'h8000_0010, 64'h0, 8'h0, 64'h600D_F00D, 1'b0, 4, 3, lat);

    // reset while a write waits: the access must vanish
    wr0 = dpi_mem_pkg::pmem_wr_calls;
    @(negedge clock);
    req_valid[1] = 1'b1;
    req_wr[1]    = 1'b1;
    req_addr[1]  = 32'h8000_0040;
    req_wdata[1] = 64'h55AA_55AA;
    req_wmask[1] = 8'h0F;
    @(posedge clock);
    #1 req_valid[1] = 1'b0;
    repeat (2) @(negedge clock);
    resetn[1] = 1'b0;
    @(posedge clock);
    #1 resetn[1] = 1'b1;
    @(negedge clock);
    check("wait_reset/rsp_valid", 64'(rsp_valid[1]), 64'd0);
    check("wait_reset/req_ready", 64'(req_ready[1]), 64'd1);
    repeat (6) @(negedge clock);
    check("wait_reset/no_dpi", 64'(dpi_mem_pkg::pmem_wr_calls), 64'(wr0));
    check("wait_reset/still_idle", 64'(rsp_valid[1]), 64'd0);
    xfer("wait_reset_rd", 1, 1'b0, 32'h8000_0040, 64'h0, 8'h0, 64'h0, 1'b0, 4, 0, lat);

    // 64-bit port: two calls per full write, upper-half-only mask touches one word
    wr0 = dpi_mem_pkg::pmem_wr_calls;
    xfer("w64_full", 2, 1'b1, 32'h8000_0008, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 64'h0, 1'b0, 2, 0, lat);
    check("w64_full/dpi_calls", 64'(dpi_mem_pkg::pmem_wr_calls - wr0), 64'd2);
    wr0 = dpi_mem_pkg::pmem_wr_calls;
    xfer("w64_hi", 2, 1'b1, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hF0, 64'h0, 1'b0, 2, 0, lat);
    check("w64_hi/dpi_calls", 64'(dpi_mem_pkg::pmem_wr_calls - wr0), 64'd1);
    xfer("r64", 2, 1'b0, 32'h8000_000C, 64'h0, 8'h0, 64'h1122_3344_CCCC_DDDD, 1'b0, 2, 0, lat);
    xfer("r32_hi_word", 0, 1'b0, 32'h8000_000C, 64'h0, 8'h0, 64'h1122_3344, 1'b0, 1, 0, lat);

    // random extra delay: exact LFSR prediction, bounds, and repeatability after reset
    xfer("rand_wr", 3, 1'b1, 32'h8000_0100, 64'h0BAD_CAFE, 8'h0F, 64'h0, 1'b0, -1, 0, lat);
    for (int run = 0; run < 2; run++) begin
      @(negedge clock);
      resetn[3] = 1'b0;
      @(posedge clock);
      #1 resetn[3] = 1'b1;
      for (int i = 0; i < 100; i++) begin
        xfer("rand_rd", 3, 1'b0, 32'h8000_0100, 64'h0, 8'h0, 64'h0BAD_CAFE, 1'b0, -1, 0, lat);
        check("rand_rd/bounds", 64'(lat >= 2 && lat <= 9), 64'd1);
        if (run == 0) lats1[i] = lat;
        else          check("rand_rd/repeat", 64'(lat), 64'(lats1[i]));
      end
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
